// File: rtl/dg0045_rom_responder.sv
// dg0045_rom_responder: program-memory responder on the far side of the
// DG0045 core's multiplexed fetch bus. It tracks the core's 8-clock machine
// cycle, drives the PC half-select, captures both 5-bit PC halves, predicts
// the core's next PC (6-bit LFSR step on PL, PU unchanged) and serves the
// instruction byte from a loadable program store.
// Optional build macro: RESP_TRACE_EN adds fetch_addr/fetch_strobe trace outputs.
module dg0045_rom_responder #(
  parameter int          ROM_AW     = 10,
  parameter logic [7:0]  RESET_BYTE = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        pc_hl,
  output logic              pc_mux,
  output logic [7:0]        rom_data,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ROM_AW-1:0] load_addr,
  input  logic [7:0]        load_data
`ifdef RESP_TRACE_EN
  ,
  output logic [ROM_AW-1:0] fetch_addr,
  output logic              fetch_strobe
`endif
);

  localparam int DEPTH = 2 ** ROM_AW;

  // Machine-cycle phase, aligned with the core's clock divider after reset.
  logic [2:0]        phase_q;
  logic [2:0]        phase_d;
  logic              pc_mux_q;
  logic [4:0]        lo_q;        // PL[4:0]
  logic [4:0]        hi_q;        // {PU, PL[5]}
  logic              cap_valid_q;
  logic [7:0]        rom_data_q;

  // Program store; contents survive reset.
  logic [7:0]        mem [DEPTH];

  logic [5:0]        pl_cur;
  logic [5:0]        pl_next;
  logic [ROM_AW-1:0] fetch_addr_d;
  logic              wr_en;
  logic              rd_en;

  // Next phase, LFSR successor of the captured PC and port handshakes.
  always_comb begin
    phase_d      = phase_q + 3'd1;
    pl_cur       = {hi_q[0], lo_q};
    pl_next      = {(pl_cur[0] == pl_cur[1]), pl_cur[5:1]};
    fetch_addr_d = ROM_AW'({hi_q[4:1], pl_next});
    // Phase 0 is reserved for the read, so writes are held off there.
    load_ready   = (phase_q != 3'd0);
    wr_en        = load_valid & load_ready;
    rd_en        = (phase_q == 3'd0) & cap_valid_q;
  end

  // Phase tracking, PC half capture and the registered instruction read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q     <= 3'd0;
      pc_mux_q    <= 1'b0;
      lo_q        <= 5'd0;
      hi_q        <= 5'd0;
      cap_valid_q <= 1'b0;
      rom_data_q  <= RESET_BYTE;
    end else begin
      phase_q  <= phase_d;
      // High only while the phase register holds 7.
      pc_mux_q <= (phase_d == 3'd7);
      if (phase_q == 3'd6) begin
        lo_q <= pc_hl;
      end
      if (phase_q == 3'd7) begin
        hi_q        <= pc_hl;
        cap_valid_q <= 1'b1;
      end
      // Held for a full machine cycle, so it is stable across the core's
      // 3->4 fetch latch edge.
      if (rd_en) begin
        rom_data_q <= mem[fetch_addr_d];
      end
    end
  end

  // Program-store write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[load_addr] <= load_data;
    end
  end

  assign pc_mux   = pc_mux_q;
  assign rom_data = rom_data_q;

`ifdef RESP_TRACE_EN
  logic [ROM_AW-1:0] fetch_addr_q;
  logic              fetch_strobe_q;

  // Trace of each real read: address and a one-clock strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_addr_q   <= '0;
      fetch_strobe_q <= 1'b0;
    end else begin
      fetch_strobe_q <= rd_en;
      if (rd_en) begin
        fetch_addr_q <= fetch_addr_d;
      end
    end
  end

  assign fetch_addr   = fetch_addr_q;
  assign fetch_strobe = fetch_strobe_q;
`endif

endmodule

// File: tb/tb_dg0045_rom_responder.sv
// Testbench for dg0045_rom_responder: a small DG0045 core model drives the
// multiplexed PC bus; directed jumps, loads and resets with hand-computed
// expected bytes, plus a per-clock model check of pc_mux, load_ready, rom_data.
module tb_dg0045_rom_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] pc_hl;
  logic       pc_mux;
  logic [7:0] rom_data;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic [9:0] load_addr = '0;
  logic [7:0] load_data = '0;
`ifdef RESP_TRACE_EN
  logic [9:0] fetch_addr;
  logic       fetch_strobe;
`endif

  dg0045_rom_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_hl      (pc_hl),
    .pc_mux     (pc_mux),
    .rom_data   (rom_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_addr  (load_addr),
    .load_data  (load_data)
`ifdef RESP_TRACE_EN
    ,
    .fetch_addr   (fetch_addr),
    .fetch_strobe (fetch_strobe)
`endif
  );

  always #5 clk = ~clk;

  // Core model state
  logic [9:0] pc_m;
  logic [9:0] fetch_m;
  logic       cap_m;
  logic [7:0] exp_data;
  logic [7:0] mem_m [1024];
  int         ph;
  bit         chk_en;
  int         n_vec = 0;
  int         n_bad = 0;

  // Core's multiplexed PC output
  assign pc_hl = pc_mux ? pc_m[9:5] : pc_m[4:0];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] succ(input logic [9:0] a);
    return {a[9:6], (a[0] == a[1]), a[5:1]};
  endfunction

  // One clock: check outputs, advance the core model.
  task automatic step();
    bit wr;
    check("pc_mux", 32'(pc_mux), 32'(ph == 7));
    check("load_ready", 32'(load_ready), 32'(ph != 0));
    if (chk_en) check("rom_data", 32'(rom_data), 32'(exp_data));
`ifdef RESP_TRACE_EN
    check("fetch_strobe", 32'(fetch_strobe), 32'(ph == 1 && cap_m));
    if (ph == 1 && cap_m) check("fetch_addr", 32'(fetch_addr), 32'(fetch_m));
`endif
    wr = load_valid && (ph != 0);
    @(posedge clk);
    #1;
    if (wr) mem_m[load_addr] = load_data;
    case (ph)
      7: begin fetch_m = succ(pc_m); cap_m = 1'b1; end
      0: if (cap_m) exp_data = mem_m[fetch_m];
      3: if (cap_m) pc_m = fetch_m;   // core latches and moves to the fetched PC
      default: ;
    endcase
    ph = (ph + 1) % 8;
  endtask

  task automatic run_to(input int p);
    while (ph != p) step();
  endtask

  task automatic load(input logic [9:0] a, input logic [7:0] d);
    bit acc;
    load_addr  = a;
    load_data  = d;
    load_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      acc = (ph != 0);
      step();
      if (acc) break;
    end
    load_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_pc_mux", 32'(pc_mux), 32'h0);
    check("rst_rom_data", 32'(rom_data), 32'h00);
    check("rst_load_ready", 32'(load_ready), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_rom_data", 32'(rom_data), 32'h00);
    rst_n    = 1'b1;
    ph       = 0;
    cap_m    = 1'b0;
    pc_m     = '0;
    fetch_m  = '0;
    exp_data = 8'h00;
  endtask

  initial begin
    logic [7:0] d;
    pc_m = '0; fetch_m = '0; cap_m = 1'b0; exp_data = 8'h00; ph = 0; chk_en = 1'b0;
    #2;
    do_reset();

    // Preload the whole store (bytes not yet written are not checked).
    for (int a = 0; a < 1024; a++) begin
      d = 8'(a * 13 + 7);
      if (a == 'h020) d = 8'hA5;
      if (a == 'h030) d = 8'h3C;
      if (a == 'h0CA) d = 8'h5E;
      if (a == 'h0BF) d = 8'h11;
      load(10'(a), d);
    end

    // Mid-cycle reset at phase 4
    run_to(4);
    #2;
    do_reset();
    chk_en = 1'b1;

    // First two fetches after reset: 0x020 then 0x030
    repeat (12) step();
    check("first_fetch", 32'(rom_data), 32'hA5);
    repeat (8) step();
    check("second_fetch", 32'(rom_data), 32'h3C);

    // Jump to PU=3, PL=0x15 -> fetch 0x0CA
    run_to(6);
    pc_m = {4'h3, 6'h15};
    run_to(4);
    check("jump_fetch", 32'(rom_data), 32'h5E);

    // LFSR fixed point PL=0x3F keeps fetching 0x0BF; write it at phase 0
    run_to(6);
    pc_m = {4'h2, 6'h3F};
    run_to(0);
    check("ready_ph0", 32'(load_ready), 32'h0);
    load(10'h0BF, 8'h99);
    run_to(4);
    check("write_old", 32'(rom_data), 32'h11);
    step();
    run_to(4);
    check("write_new", 32'(rom_data), 32'h99);

    // Second mid-cycle reset; refetch from 0x020
    #2;
    do_reset();
    repeat (12) step();
    check("reset_refetch", 32'(rom_data), 32'hA5);

    // 64 consecutive LFSR steps in page 1
    run_to(6);
    pc_m = {4'h1, 6'h01};
    repeat (64 * 8) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, expected finish before 1ms");
    $fatal(1);
  end

endmodule
